mem_access_ctrl: RTL

- Memory access sequencer between the CPU control unit / MAR-MDR datapath and the 512-word RAM.
- Accepts a single read or write request and latches address and data.
- Drives the RAM's level-sensitive `address`, `data_in`, `read` and `write` inputs with setup, strobe and hold phases.
- Captures the RAM's `data_out` into an MDR-style register and pulses `done`, so the control unit can sequence ld/st/fetch with deterministic latency.

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: SETUP / ACCESS / HOLD around a level-sensitive RAM, MDR-style read capture.
// Optional address bounds check enabled by defining MEM_CTRL_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 512,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data_out
);

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       we_q;
    logic       fault_q, fault_nx;
    logic       addr_oob;
    logic       load_rdata;
    logic       busy_nx, done_nx, err_nx, rd_nx, wr_nx;

    // With the check disabled this folds to 0, so every access is strobed and err stays low.
    assign addr_oob = BOUNDS_EN && (ram_address >= ADDR_W'(MEM_DEPTH));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        fault_nx   = fault_q;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
                cnt_nx   = 4'(WAIT_CYCLES);
                fault_nx = addr_oob;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx   = HOLD;
                    load_rdata = !we_q && !fault_q;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == HOLD);
        err_nx  = done_nx && fault_nx;
        rd_nx   = (state_nx == ACCESS) && !fault_nx && !we_q;
        wr_nx   = (state_nx == ACCESS) && !fault_nx && we_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt         <= '0;
            fault_q     <= 1'b0;
            we_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            rdata       <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else begin
            cnt       <= cnt_nx;
            fault_q   <= fault_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
            ram_read  <= rd_nx;
            ram_write <= wr_nx;
            if (state == IDLE && req) begin
                ram_address <= addr;
                ram_data_in <= wdata;
                we_q        <= we;
            end
            if (load_rdata) begin
                rdata <= ram_data_out;
            end
        end
    end

endmodule
